// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the pipeline-side hazard inputs (ID/EX register
// fields, redirect, data-memory handshake) and the pipeline-register control
// outputs produced by hazard_ctrl.
//   master : pipeline side, drives hazard inputs, receives enables/flushes
//   slave  : hazard_ctrl side
interface hazard_ctrl_if;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       uses_rs1_id;
  logic       uses_rs2_id;
  logic [4:0] rd_ex;
  logic       mem_read_ex;
  logic       redirect_ex;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       if_id_flush;
  logic       id_ex_flush;

  modport master (
    output rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, rd_ex,
           mem_read_ex, redirect_ex, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush
  );

  modport slave (
    input  rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, rd_ex,
           mem_read_ex, redirect_ex, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall controller.
//   clk, rst_n    : clock, asynchronous active-low reset
//   hz (slave)    : ID/EX hazard inputs, dmem handshake, register enables/flushes
//   err_clr       : clears the sticky memory-timeout flag
//   mem_wait      : controller is waiting on data memory
//   err_timeout   : sticky flag, memory freeze lasted TIMEOUT cycles
//   stall_cycles  : saturating count of stall/freeze cycles
//   flush_events  : saturating count of applied redirect flushes
// Enables/flushes are combinational (zero latency); status and counters are
// registered.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz,
  input  logic             err_clr,
  output logic             mem_wait,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [WCNT_W-1:0] wait_cnt_r;
  logic [WCNT_W-1:0] wait_cnt_next_s;
  logic              freeze_s;
  logic              load_use_s;
  logic              err_set_s;
  logic              stall_inc_s;
  logic              flush_inc_s;

  // Hazard condition terms from the current pipeline contents.
  always_comb begin
    freeze_s   = hz.dmem_req & ~hz.dmem_ready;
    load_use_s = hz.mem_read_ex & (hz.rd_ex != 5'd0) &
                 ((hz.uses_rs1_id & (hz.rs1_id == hz.rd_ex)) |
                  (hz.uses_rs2_id & (hz.rs2_id == hz.rd_ex)));
    stall_inc_s = freeze_s | (load_use_s & ~hz.redirect_ex);
    flush_inc_s = hz.redirect_ex & ~freeze_s;
  end

  // Pipeline register control, priority freeze > redirect > load-use.
  // Everything is held off while reset is asserted.
  always_comb begin
    hz.pc_en       = 1'b0;
    hz.if_id_en    = 1'b0;
    hz.id_ex_en    = 1'b0;
    hz.ex_mem_en   = 1'b0;
    hz.if_id_flush = 1'b0;
    hz.id_ex_flush = 1'b0;
    if (!rst_n || freeze_s) begin
      hz.pc_en = 1'b0;
    end else if (hz.redirect_ex) begin
      // Squashing the dependent instruction makes any load-use moot.
      hz.pc_en       = 1'b1;
      hz.if_id_en    = 1'b1;
      hz.id_ex_en    = 1'b1;
      hz.ex_mem_en   = 1'b1;
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (load_use_s) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      hz.id_ex_en    = 1'b1;
      hz.ex_mem_en   = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else begin
      hz.pc_en     = 1'b1;
      hz.if_id_en  = 1'b1;
      hz.id_ex_en  = 1'b1;
      hz.ex_mem_en = 1'b1;
    end
  end

  // Memory-wait FSM next state and saturating wait counter.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (freeze_s) begin
          state_next_s    = ST_WAIT;
          wait_cnt_next_s = WCNT_W'(1);
        end else begin
          wait_cnt_next_s = WCNT_W'(0);
        end
      end
      ST_WAIT: begin
        if (freeze_s) begin
          if (wait_cnt_r != TIMEOUT_V) begin
            wait_cnt_next_s = wait_cnt_r + WCNT_W'(1);
          end else begin
            wait_cnt_next_s = wait_cnt_r;
          end
        end else begin
          state_next_s    = ST_RUN;
          wait_cnt_next_s = WCNT_W'(0);
        end
      end
      default: begin
        state_next_s    = ST_RUN;
        wait_cnt_next_s = WCNT_W'(0);
      end
    endcase
    // Fires only on the transition into TIMEOUT, not while saturated there.
    err_set_s = freeze_s & (wait_cnt_next_s == TIMEOUT_V) & (wait_cnt_r != TIMEOUT_V);
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= WCNT_W'(0);
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Sticky timeout flag; a set on the same edge wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (err_set_s) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= err_timeout;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= CNT_W'(0);
      flush_events <= CNT_W'(0);
    end else begin
      if (stall_inc_s && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_inc_s && (flush_events != {CNT_W{1'b1}})) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

  assign mem_wait = (state_r == ST_WAIT);
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl. A second
// instance with CNT_W=4 covers counter saturation.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        err_clr;
  logic        mem_wait, err_timeout;
  logic [31:0] stall_cycles, flush_events;
  logic        mem_wait4, err_timeout4;
  logic [3:0]  stall_cycles4, flush_events4;

  hazard_ctrl_if hz ();
  hazard_ctrl_if hz4 ();

  hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz), .err_clr(err_clr),
    .mem_wait(mem_wait), .err_timeout(err_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hz(hz4), .err_clr(err_clr),
    .mem_wait(mem_wait4), .err_timeout(err_timeout4),
    .stall_cycles(stall_cycles4), .flush_events(flush_events4)
  );

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}
  logic [5:0] ctl, ctl4;
  assign ctl  = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.if_id_flush, hz.id_ex_flush};
  assign ctl4 = {hz4.pc_en, hz4.if_id_en, hz4.id_ex_en, hz4.ex_mem_en, hz4.if_id_flush, hz4.id_ex_flush};

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;

  task automatic idle();
    hz.rs1_id = 5'd0; hz.rs2_id = 5'd0; hz.uses_rs1_id = 1'b0; hz.uses_rs2_id = 1'b0;
    hz.rd_ex = 5'd0; hz.mem_read_ex = 1'b0; hz.redirect_ex = 1'b0;
    hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
    hz4.rs1_id = 5'd0; hz4.rs2_id = 5'd0; hz4.uses_rs1_id = 1'b0; hz4.uses_rs2_id = 1'b0;
    hz4.rd_ex = 5'd0; hz4.mem_read_ex = 1'b0; hz4.redirect_ex = 1'b0;
    hz4.dmem_req = 1'b0; hz4.dmem_ready = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic set_load_use();
    hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd5; hz.rs2_id = 5'd5; hz.uses_rs2_id = 1'b1;
    hz.rs1_id = 5'd3; hz.uses_rs1_id = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; idle();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b000000); end
    checks++; if (mem_wait !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL reset_status got=%b%b exp=00", mem_wait, err_timeout); end
    checks++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events); end
    #8 rst_n = 1'b1;
    #1;
    checks++; if (ctl !== 6'b111100) begin failures++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, 6'b111100); end
  endtask

  task automatic test_load_use();
    tick();
    set_load_use();
    #1;
    checks++; if (ctl !== 6'b001101) begin failures++; $display("FAIL load_use_ctl got=%b exp=%b", ctl, 6'b001101); end
    tick(); exp_stall = exp_stall + 32'd1;
    idle();
    #1;
    checks++; if (stall_cycles !== exp_stall) begin failures++; $display("FAIL load_use_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    checks++; if (ctl !== 6'b111100) begin failures++; $display("FAIL load_use_clears got=%b exp=%b", ctl, 6'b111100); end
    // rd_ex == 0 must never stall
    hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd0; hz.rs1_id = 5'd0; hz.uses_rs1_id = 1'b1;
    #1;
    checks++; if (ctl !== 6'b111100) begin failures++; $display("FAIL rd_zero_ctl got=%b exp=%b", ctl, 6'b111100); end
    tick();
    // matching register that is not actually read
    hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd7; hz.rs2_id = 5'd7; hz.uses_rs2_id = 1'b0;
    hz.rs1_id = 5'd2; hz.uses_rs1_id = 1'b1;
    #1;
    checks++; if (ctl !== 6'b111100) begin failures++; $display("FAIL unused_src_ctl got=%b exp=%b", ctl, 6'b111100); end
    tick();
    idle();
    checks++; if (stall_cycles !== exp_stall) begin failures++; $display("FAIL no_stall_count got=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_back_to_back();
    set_load_use(); hz.redirect_ex = 1'b1;
    #1;
    checks++; if (ctl !== 6'b111111) begin failures++; $display("FAIL redirect_lu_ctl got=%b exp=%b", ctl, 6'b111111); end
    tick(); exp_flush = exp_flush + 32'd1;
    checks++; if (stall_cycles !== exp_stall) begin failures++; $display("FAIL redirect_lu_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    checks++; if (flush_events !== exp_flush) begin failures++; $display("FAIL redirect_lu_flush got=%0d exp=%0d", flush_events, exp_flush); end
    idle(); hz.redirect_ex = 1'b1;
    #1;
    checks++; if (ctl !== 6'b111111) begin failures++; $display("FAIL redirect2_ctl got=%b exp=%b", ctl, 6'b111111); end
    tick(); exp_flush = exp_flush + 32'd1;
    idle();
    checks++; if (flush_events !== exp_flush) begin failures++; $display("FAIL redirect2_flush got=%0d exp=%0d", flush_events, exp_flush); end
  endtask

  task automatic test_freeze_redirect();
    hz.redirect_ex = 1'b1; hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL freeze_ctl cyc=%0d got=%b exp=%b", i, ctl, 6'b000000); end
      checks++; if (mem_wait !== (i > 1)) begin failures++; $display("FAIL freeze_wait cyc=%0d got=%b exp=%b", i, mem_wait, (i > 1)); end
      tick(); exp_stall = exp_stall + 32'd1;
    end
    hz.dmem_ready = 1'b1;
    #1;
    checks++; if (ctl !== 6'b111111) begin failures++; $display("FAIL ready_flush_ctl got=%b exp=%b", ctl, 6'b111111); end
    checks++; if (mem_wait !== 1'b1) begin failures++; $display("FAIL ready_wait got=%b exp=1", mem_wait); end
    tick(); exp_flush = exp_flush + 32'd1;
    idle();
    checks++; if (mem_wait !== 1'b0) begin failures++; $display("FAIL wait_exit got=%b exp=0", mem_wait); end
    checks++; if (stall_cycles !== exp_stall || flush_events !== exp_flush) begin failures++; $display("FAIL freeze_counts got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_events, exp_stall, exp_flush); end
  endtask

  task automatic test_timeout();
    hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick(); exp_stall = exp_stall + 32'd1;
      if (i == 15) begin
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", err_timeout); end
      end
    end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_set got=%b exp=1", err_timeout); end
    hz.dmem_ready = 1'b1;
    tick();
    idle();
    checks++; if (err_timeout !== 1'b1 || mem_wait !== 1'b0) begin failures++; $display("FAIL timeout_sticky got=%b%b exp=10", err_timeout, mem_wait); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", err_timeout); end
    checks++; if (stall_cycles !== exp_stall) begin failures++; $display("FAIL timeout_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_reset_mid_wait();
    hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
    for (int i = 1; i <= 18; i++) tick();
    checks++; if (err_timeout !== 1'b1 || mem_wait !== 1'b1) begin failures++; $display("FAIL pre_reset_state got=%b%b exp=11", err_timeout, mem_wait); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_wait !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL async_reset_status got=%b%b exp=00", mem_wait, err_timeout); end
    checks++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin failures++; $display("FAIL async_reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events); end
    checks++; if (ctl !== 6'b000000) begin failures++; $display("FAIL async_reset_ctl got=%b exp=%b", ctl, 6'b000000); end
    idle();
    #2 rst_n = 1'b1;
    tick();
    checks++; if (stall_cycles !== 32'd0 || mem_wait !== 1'b0) begin failures++; $display("FAIL after_reset got=%0d/%b exp=0/0", stall_cycles, mem_wait); end
  endtask

  task automatic test_saturation();
    hz4.mem_read_ex = 1'b1; hz4.rd_ex = 5'd9; hz4.rs1_id = 5'd9; hz4.uses_rs1_id = 1'b1;
    #1;
    checks++; if (ctl4 !== 6'b001101) begin failures++; $display("FAIL sat_ctl got=%b exp=%b", ctl4, 6'b001101); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        checks++; if (stall_cycles4 !== 4'd14) begin failures++; $display("FAIL sat_count14 got=%0d exp=14", stall_cycles4); end
      end
    end
    idle();
    checks++; if (stall_cycles4 !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_cycles4); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_freeze_redirect();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
